mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/grant, read-return and memory-port signals of the three-way memory port arbiter.
// The arbiter connects through 'master'; the requesters and memory model connect through 'slave'.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_gnt;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;

    logic              ver_req;
    logic [ADDR_W-1:0] ver_addr;
    logic              ver_gnt;
    logic [DATA_W-1:0] ver_rdata;
    logic              ver_rvalid;

    logic              mem_read_flag;
    logic [ADDR_W-1:0] mem_READ_addr;
    logic [DATA_W-1:0] HRDATA_fromMem;
    logic              mem_write_flag;
    logic [ADDR_W-1:0] mem_WRITE_addr;
    logic [DATA_W-1:0] HWDATA_toMem;

    logic [1:0]        owner;

    modport master (
        input  core_req, core_addr, cpu_req, cpu_addr, cpu_wdata,
               ver_req, ver_addr, HRDATA_fromMem,
        output core_gnt, core_rdata, core_rvalid, cpu_gnt,
               ver_gnt, ver_rdata, ver_rvalid,
               mem_read_flag, mem_READ_addr, mem_write_flag, mem_WRITE_addr,
               HWDATA_toMem, owner
    );

    modport slave (
        output core_req, core_addr, cpu_req, cpu_addr, cpu_wdata,
               ver_req, ver_addr, HRDATA_fromMem,
        input  core_gnt, core_rdata, core_rvalid, cpu_gnt,
               ver_gnt, ver_rdata, ver_rvalid,
               mem_read_flag, mem_READ_addr, mem_write_flag, mem_WRITE_addr,
               HWDATA_toMem, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between CoreSystem (read), CPU (write) and Verifier (read),
// with bounded bursts and tag-routed read returns one cycle after each read beat.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input logic                HCLK,
    input logic                HRESET,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        G_CORE = 2'd1,
        G_CPU  = 2'd2,
        G_VER  = 2'd3
    } state_t;

    state_t            state;
    state_t            last_owner;
    state_t            next_sel;
    logic [4:0]        beat_cnt;
    logic              core_gnt_q, cpu_gnt_q, ver_gnt_q;
    logic              tag_core, tag_ver;
    logic [DATA_W-1:0] core_rdata_q, ver_rdata_q;
    logic              core_beat, cpu_beat, ver_beat;
    logic              own_req, own_beat, burst_done, release_now;
    logic [2:0]        req_vec;

    // Search starts at the requester after 'last' and wraps round to 'last' itself.
    function automatic state_t rr_pick(input state_t last, input logic [2:0] req);
        state_t pick;
        case (last)
            G_CORE:  pick = req[1] ? G_CPU  : req[2] ? G_VER  : req[0] ? G_CORE : IDLE;
            G_CPU:   pick = req[2] ? G_VER  : req[0] ? G_CORE : req[1] ? G_CPU  : IDLE;
            default: pick = req[0] ? G_CORE : req[1] ? G_CPU  : req[2] ? G_VER  : IDLE;
        endcase
        return pick;
    endfunction

    always_comb begin
        req_vec     = {bus.ver_req, bus.cpu_req, bus.core_req};
        core_beat   = core_gnt_q & bus.core_req;
        cpu_beat    = cpu_gnt_q  & bus.cpu_req;
        ver_beat    = ver_gnt_q  & bus.ver_req;
        own_beat    = core_beat | cpu_beat | ver_beat;
        own_req     = own_beat;
        burst_done  = own_beat && (beat_cnt == 5'(MAX_BURST - 1));
        release_now = (state != IDLE) && (!own_req || burst_done);
        next_sel    = rr_pick(last_owner, req_vec);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= IDLE;
            last_owner   <= G_VER;
            beat_cnt     <= '0;
            core_gnt_q   <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            ver_gnt_q    <= 1'b0;
            tag_core     <= 1'b0;
            tag_ver      <= 1'b0;
            core_rdata_q <= '0;
            ver_rdata_q  <= '0;
        end else begin
            tag_core <= core_beat;
            tag_ver  <= ver_beat;
            if (tag_core) core_rdata_q <= bus.HRDATA_fromMem;
            if (tag_ver)  ver_rdata_q  <= bus.HRDATA_fromMem;

            // last_owner equals state while granted, so a release re-arbitrates starting after the current owner.
            if (state == IDLE || release_now) begin
                state      <= next_sel;
                beat_cnt   <= '0;
                core_gnt_q <= (next_sel == G_CORE);
                cpu_gnt_q  <= (next_sel == G_CPU);
                ver_gnt_q  <= (next_sel == G_VER);
                if (next_sel != IDLE) last_owner <= next_sel;
            end else if (own_beat) begin
                beat_cnt <= beat_cnt + 5'd1;
            end
        end
    end

    assign bus.core_gnt       = core_gnt_q;
    assign bus.cpu_gnt        = cpu_gnt_q;
    assign bus.ver_gnt        = ver_gnt_q;
    assign bus.owner          = state;

    assign bus.mem_read_flag  = core_beat | ver_beat;
    assign bus.mem_READ_addr  = core_beat ? bus.core_addr : (ver_beat ? bus.ver_addr : '0);
    assign bus.mem_write_flag = cpu_beat;
    assign bus.mem_WRITE_addr = cpu_beat ? bus.cpu_addr  : '0;
    assign bus.HWDATA_toMem   = cpu_beat ? bus.cpu_wdata : '0;

    // Memory data arrives the cycle after the beat; pass it straight through, then hold it.
    assign bus.core_rvalid    = tag_core;
    assign bus.core_rdata     = tag_core ? bus.HRDATA_fromMem : core_rdata_q;
    assign bus.ver_rvalid     = tag_ver;
    assign bus.ver_rdata      = tag_ver ? bus.HRDATA_fromMem : ver_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each step queues the expected port state for its cycle,
// and a negedge monitor pops and compares it against the DUT.
module tb_mem_port_arbiter;
    logic HCLK;
    logic HRESET;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [2:0]  gnt;   // {core, cpu, ver}
        logic [1:0]  owner;
        logic        rd;
        logic [31:0] raddr;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        crv;
        logic        vrv;
        logic [31:0] crd;
        logic [31:0] vrd;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          checks   = 0;
    int          failures = 0;
    logic        exp_pc, exp_pv;
    logic [31:0] exp_crd, exp_vrd;
    logic        use_fixed;
    logic [31:0] fixed_hd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        exp_pc  = 1'b0;
        exp_pv  = 1'b0;
        exp_crd = '0;
        exp_vrd = '0;
    endtask

    // Queue this cycle's expected outputs, then advance to just after the next rising edge.
    task automatic expect_cycle(input logic [1:0] own, input logic rd, input logic [31:0] ra,
                                input logic wr, input logic [31:0] wa, input logic [31:0] wd);
        exp_t e;
        bus.HRDATA_fromMem = use_fixed ? fixed_hd : $urandom();
        if (exp_pc) exp_crd = bus.HRDATA_fromMem;
        if (exp_pv) exp_vrd = bus.HRDATA_fromMem;
        e.gnt   = {own == 2'd1, own == 2'd2, own == 2'd3};
        e.owner = own;
        e.rd    = rd;
        e.raddr = rd ? ra : '0;
        e.wr    = wr;
        e.waddr = wr ? wa : '0;
        e.wdata = wr ? wd : '0;
        e.crv   = exp_pc;
        e.vrv   = exp_pv;
        e.crd   = exp_crd;
        e.vrd   = exp_vrd;
        sb.push_back(e);
        exp_pc = rd && (own == 2'd1);
        exp_pv = rd && (own == 2'd3);
        @(posedge HCLK);
        #1;
    endtask

    task automatic t_none(input logic [1:0] own);
        expect_cycle(own, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic t_rd(input logic [1:0] own, input logic [31:0] a);
        expect_cycle(own, 1'b1, a, 1'b0, '0, '0);
    endtask

    task automatic t_wr(input logic [31:0] a, input logic [31:0] d);
        expect_cycle(2'd2, 1'b0, '0, 1'b1, a, d);
    endtask

    always @(negedge HCLK) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("gnt",         {29'd0, bus.core_gnt, bus.cpu_gnt, bus.ver_gnt}, {29'd0, e_mon.gnt});
            chk("owner",       {30'd0, bus.owner}, {30'd0, e_mon.owner});
            chk("read_flag",   {31'd0, bus.mem_read_flag}, {31'd0, e_mon.rd});
            chk("read_addr",   bus.mem_READ_addr, e_mon.raddr);
            chk("write_flag",  {31'd0, bus.mem_write_flag}, {31'd0, e_mon.wr});
            chk("write_addr",  bus.mem_WRITE_addr, e_mon.waddr);
            chk("write_data",  bus.HWDATA_toMem, e_mon.wdata);
            chk("core_rvalid", {31'd0, bus.core_rvalid}, {31'd0, e_mon.crv});
            chk("ver_rvalid",  {31'd0, bus.ver_rvalid}, {31'd0, e_mon.vrv});
            chk("core_rdata",  bus.core_rdata, e_mon.crd);
            chk("ver_rdata",   bus.ver_rdata, e_mon.vrd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        bus.core_req = 1'b0; bus.core_addr = '0;
        bus.cpu_req  = 1'b0; bus.cpu_addr  = '0; bus.cpu_wdata = '0;
        bus.ver_req  = 1'b0; bus.ver_addr  = '0;
        bus.HRDATA_fromMem = '0;
        use_fixed = 1'b0;
        fixed_hd  = '0;
        clear_trk();
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        t_none(2'd0);

        // All three requesting: 16 beats each in core, cpu, ver order, then back to core.
        bus.core_req = 1'b1; bus.core_addr = 32'h1000;
        bus.cpu_req  = 1'b1; bus.cpu_addr  = 32'h2000; bus.cpu_wdata = 32'h55;
        bus.ver_req  = 1'b1; bus.ver_addr  = 32'h3000;
        t_none(2'd0);
        for (int i = 0; i < 16; i++) t_rd(2'd1, 32'h1000);
        for (int i = 0; i < 16; i++) t_wr(32'h2000, 32'h55);
        for (int i = 0; i < 16; i++) t_rd(2'd3, 32'h3000);
        for (int i = 0; i < 2; i++)  t_rd(2'd1, 32'h1000);
        bus.core_req = 1'b0; bus.cpu_req = 1'b0; bus.ver_req = 1'b0;
        t_none(2'd1);
        t_none(2'd0);

        // CPU writes two words, then drops req while still granted.
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'hA;
        t_none(2'd0);
        t_wr(32'h100, 32'hA);
        bus.cpu_addr = 32'h104; bus.cpu_wdata = 32'hB;
        t_wr(32'h104, 32'hB);
        bus.cpu_req = 1'b0; bus.cpu_addr = 32'h108; bus.cpu_wdata = 32'hC;
        t_none(2'd2);
        t_none(2'd0);

        // Single core read returning 0xDEADBEEF.
        bus.core_req = 1'b1; bus.core_addr = 32'h40;
        t_none(2'd0);
        t_rd(2'd1, 32'h40);
        bus.core_req = 1'b0;
        use_fixed = 1'b1; fixed_hd = 32'hDEADBEEF;
        t_none(2'd1);
        use_fixed = 1'b0;
        t_none(2'd0);

        // Core alone: re-granted back to back; ver joins on the 48th beat (end of third burst).
        bus.core_req = 1'b1; bus.core_addr = 32'h500;
        t_none(2'd0);
        for (int i = 0; i < 47; i++) t_rd(2'd1, 32'h500);
        bus.ver_req = 1'b1; bus.ver_addr = 32'h3300;
        t_rd(2'd1, 32'h500);
        bus.core_req = 1'b0;
        for (int i = 0; i < 3; i++) t_rd(2'd3, 32'h3300);

        // Reset pulse during the ver burst, then all requesting: core first.
        HRESET = 1'b1;
        t_rd(2'd3, 32'h3300);
        clear_trk();
        HRESET = 1'b0;
        bus.core_req = 1'b1; bus.core_addr = 32'h600;
        bus.cpu_req  = 1'b1; bus.ver_req   = 1'b1;
        t_none(2'd0);
        t_rd(2'd1, 32'h600);
        bus.core_req = 1'b0; bus.cpu_req = 1'b0; bus.ver_req = 1'b0;
        t_none(2'd1);
        t_none(2'd0);

        chk("scoreboard_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
